// File: rtl/gate_bist_pkg.sv
// Shared definitions for the basic_gates BIST checker: FSM states,
// gate_out bit packing and the number of stimulus vectors per sweep.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } bist_state_e;

    // gate_out packing: [6]=and ... [0]=xnor
    localparam int AND_IDX  = 6;
    localparam int OR_IDX   = 5;
    localparam int NOT_IDX  = 4;
    localparam int NAND_IDX = 3;
    localparam int NOR_IDX  = 2;
    localparam int XOR_IDX  = 1;
    localparam int XNOR_IDX = 0;

    localparam int NUM_VEC = 4;

endpackage

// File: rtl/gate_golden_model.sv
// Combinational reference for the seven basic gates, packed in the
// same order as the basic_gates response bus.
module gate_golden_model
    import gate_bist_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    output logic [6:0] exp_o
);

    // Expected gate outputs for the current {a,b}
    always_comb begin
        exp_o           = 7'b000_0000;
        exp_o[AND_IDX]  = a_i & b_i;
        exp_o[OR_IDX]   = a_i | b_i;
        exp_o[NOT_IDX]  = ~a_i;
        exp_o[NAND_IDX] = ~(a_i & b_i);
        exp_o[NOR_IDX]  = ~(a_i | b_i);
        exp_o[XOR_IDX]  = a_i ^ b_i;
        exp_o[XNOR_IDX] = ~(a_i ^ b_i);
    end

endmodule

// File: rtl/gate_bist_checker.sv
// BIST sequencer and response checker for basic_gates. Sweeps all four
// {a,b} vectors PASSES times, holds each for SETTLE_CYCLES cycles, then
// compares gate_out against the golden model for one cycle.
// Optional first-error logging: define GATE_BIST_ERRLOG_EN.
module gate_bist_checker
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic             a_o,
    output logic             b_o,
    input  logic [6:0]       gate_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic [1:0]       first_err_vec_o,
    output logic [6:0]       first_err_mask_o
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [CW-1:0]    CNT_LOAD  = CW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0]    LAST_PASS = PW'(PASSES - 1);
    localparam logic [1:0]       LAST_VEC  = 2'(NUM_VEC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    bist_state_e      state_q, state_d;
    logic [1:0]       vec_q, vec_d;      // doubles as the registered {a,b}
    logic [PW-1:0]    pidx_q, pidx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic [6:0] golden_s;
    logic [6:0] diff_s;
    logic       mismatch_s;
    logic       accept_s;

    gate_golden_model u_golden (
        .a_i   (vec_q[1]),
        .b_i   (vec_q[0]),
        .exp_o (golden_s)
    );

    assign diff_s     = gate_out_i ^ golden_s;
    assign mismatch_s = |diff_s;
    assign accept_s   = (state_q == ST_IDLE) && start_i;

    // Next-state and datapath updates for the sweep sequencer
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        pidx_d  = pidx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_DRIVE;
                    vec_d   = 2'b00;
                    pidx_d  = {PW{1'b0}};
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = {ERR_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_SAMPLE: begin
                if (mismatch_s && (err_q != ERR_MAX)) begin
                    err_d = err_q + ERR_W'(1);
                end else begin
                    err_d = err_q;
                end
                if ((vec_q == LAST_VEC) && (pidx_q == LAST_PASS)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_d == {ERR_W{1'b0}});
                    vec_d   = 2'b00;
                end else begin
                    state_d = ST_DRIVE;
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = CNT_LOAD;
                    if (vec_q == LAST_VEC) begin
                        pidx_d = pidx_q + PW'(1);
                    end else begin
                        pidx_d = pidx_q;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                vec_d   = 2'b00;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            vec_q   <= 2'b00;
            pidx_q  <= {PW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= {ERR_W{1'b0}};
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            pidx_q  <= pidx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
        end
    end

`ifdef GATE_BIST_ERRLOG_EN
    logic [1:0] fvec_q, fvec_d;
    logic [6:0] fmask_q, fmask_d;

    // Capture the first mismatching vector of a run; a zero error count
    // means no mismatch has been seen yet in this run
    always_comb begin
        fvec_d  = fvec_q;
        fmask_d = fmask_q;
        if (accept_s) begin
            fvec_d  = 2'b00;
            fmask_d = 7'b000_0000;
        end else if ((state_q == ST_SAMPLE) && mismatch_s && (err_q == {ERR_W{1'b0}})) begin
            fvec_d  = vec_q;
            fmask_d = diff_s;
        end else begin
            fvec_d  = fvec_q;
        end
    end

    // First-error log registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fvec_q  <= 2'b00;
            fmask_q <= 7'b000_0000;
        end else begin
            fvec_q  <= fvec_d;
            fmask_q <= fmask_d;
        end
    end

    assign first_err_vec_o  = fvec_q;
    assign first_err_mask_o = fmask_q;
`else
    assign first_err_vec_o  = 2'b00;
    assign first_err_mask_o = 7'b000_0000;
`endif

    assign a_o       = vec_q[1];
    assign b_o       = vec_q[0];
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign err_cnt_o = err_q;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Directed bench for gate_bist_checker: two instances (S=2,P=1,ERR_W=4
// and S=1,P=2,ERR_W=2) each fed by a bench model of basic_gates with
// selectable fault modes.
module tb_gate_bist_checker;

`ifdef GATE_BIST_ERRLOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic go  = 1'b0;
    logic sel = 1'b0;
    logic [2:0] mode0 = 3'd0;
    logic [2:0] mode1 = 3'd0;
    logic start0, start1;

    logic a0, b0, busy0, done0, pass0;
    logic [3:0] err0;
    logic [1:0] fvec0;
    logic [6:0] fmask0, gout0;
    logic a1, b1, busy1, done1, pass1;
    logic [1:0] err1;
    logic [1:0] fvec1;
    logic [6:0] fmask1, gout1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign start0 = go & ~sel;
    assign start1 = go & sel;

    // Reference gates, packed {and,or,not,nand,nor,xor,xnor}
    function automatic logic [6:0] gold(input logic a, input logic b);
        return {a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
    endfunction

    // basic_gates stand-in with fault injection
    function automatic logic [6:0] gates(input logic [2:0] m, input logic a, input logic b);
        logic [6:0] g;
        g = gold(a, b);
        case (m)
            3'd1:    return g & 7'b111_1110;                      // xnor stuck at 0
            3'd2:    return ~g;                                   // every bit wrong
            3'd3:    return g | 7'b100_0000;                      // and stuck at 1
            3'd4:    return (a & b) ? (g ^ 7'b000_0100) : g;      // nor flips on 11 only
            default: return g;
        endcase
    endfunction

    assign gout0 = gates(mode0, a0, b0);
    assign gout1 = gates(mode1, a1, b1);

    gate_bist_checker #(.SETTLE_CYCLES(2), .PASSES(1), .ERR_W(4)) u0 (
        .clk_i(clk), .rst_i(rst), .start_i(start0), .a_o(a0), .b_o(b0),
        .gate_out_i(gout0), .busy_o(busy0), .done_o(done0), .pass_o(pass0),
        .err_cnt_o(err0), .first_err_vec_o(fvec0), .first_err_mask_o(fmask0)
    );

    gate_bist_checker #(.SETTLE_CYCLES(1), .PASSES(2), .ERR_W(2)) u1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .a_o(a1), .b_o(b1),
        .gate_out_i(gout1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
        .err_cnt_o(err1), .first_err_vec_o(fvec1), .first_err_mask_o(fmask1)
    );

    logic        m_busy, m_done, m_pass;
    logic [1:0]  m_ab, m_fvec;
    logic [6:0]  m_fmask;
    logic [31:0] m_err;

    always_comb begin
        m_busy  = sel ? busy1 : busy0;
        m_done  = sel ? done1 : done0;
        m_pass  = sel ? pass1 : pass0;
        m_ab    = sel ? {a1, b1} : {a0, b0};
        m_fvec  = sel ? fvec1 : fvec0;
        m_fmask = sel ? fmask1 : fmask0;
        m_err   = sel ? 32'(err1) : 32'(err0);
    end

    typedef struct {
        logic       sel;
        logic [2:0] mode;
        int         exp_n;
        int         exp_err;
        logic       exp_pass;
        logic [1:0] exp_vec;
        logic [6:0] exp_mask;
    } vec_t;

    vec_t tbl[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (m_done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic run_entry(input vec_t t, input bit trace);
        int n;
        sel = t.sel;
        if (t.sel) mode1 = t.mode;
        else       mode0 = t.mode;
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("busy_on_accept", 32'(m_busy), 32'd1);
        chk("ab_first", 32'(m_ab), 32'd0);
        chk("err_cleared", m_err, 32'd0);
        chk("pass_cleared", 32'(m_pass), 32'd0);
        n = 0;
        while (m_done !== 1'b1 && n < 100) begin
            if (trace) chk("ab_step", 32'(m_ab), 32'(n / 3));
            tick();
            n++;
        end
        chk("done_latency", 32'(n), 32'(t.exp_n));
        chk("err_cnt", m_err, 32'(t.exp_err));
        chk("pass", 32'(m_pass), 32'(t.exp_pass));
        chk("busy_in_done", 32'(m_busy), 32'd1);
        chk("first_err_vec", 32'(m_fvec), LOG ? 32'(t.exp_vec) : 32'd0);
        chk("first_err_mask", 32'(m_fmask), LOG ? 32'(t.exp_mask) : 32'd0);
        tick();
        chk("done_pulse_end", 32'(m_done), 32'd0);
        chk("busy_idle", 32'(m_busy), 32'd0);
        chk("ab_idle", 32'(m_ab), 32'd0);
        chk("pass_held", 32'(m_pass), 32'(t.exp_pass));
    endtask

    initial begin
        int n;
        int n2;
        //          sel   mode  N   err pass vec    mask
        tbl[0] = '{1'b0, 3'd0, 12, 0, 1'b1, 2'b00, 7'b000_0000};
        tbl[1] = '{1'b0, 3'd1, 12, 2, 1'b0, 2'b00, 7'b000_0001};
        tbl[2] = '{1'b0, 3'd4, 12, 1, 1'b0, 2'b11, 7'b000_0100};
        tbl[3] = '{1'b0, 3'd2, 12, 4, 1'b0, 2'b00, 7'b111_1111};
        tbl[4] = '{1'b0, 3'd3, 12, 3, 1'b0, 2'b00, 7'b100_0000};
        tbl[5] = '{1'b1, 3'd2, 16, 3, 1'b0, 2'b00, 7'b111_1111};
        tbl[6] = '{1'b1, 3'd0, 16, 0, 1'b1, 2'b00, 7'b000_0000};

        rst = 1'b1;
        tick();
        tick();
        chk("rst_ab0", 32'({a0, b0}), 32'd0);
        chk("rst_flags0", 32'({busy0, done0, pass0}), 32'd0);
        chk("rst_err0", 32'(err0), 32'd0);
        chk("rst_log0", 32'({fvec0, fmask0}), 32'd0);
        chk("rst_all1", 32'({a1, b1, busy1, done1, pass1, err1, fvec1, fmask1}), 32'd0);
        rst = 1'b0;
        repeat (7) tick();

        for (int i = 0; i < 7; i++) begin
            run_entry(tbl[i], (i == 0));
            tick();
        end

        // start pulses during a run must not disturb it
        sel = 1'b0;
        mode0 = 3'd0;
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        wait_done(100, n);
        chk("extra_start_latency", 32'(n + 4), 32'd12);
        tick();
        tick();
        tick();
        chk("extra_start_no_rerun", 32'(m_busy), 32'd0);

        // start held high: back-to-back runs with one IDLE cycle between
        go = 1'b1;
        tick();
        wait_done(100, n);
        chk("held_first_latency", 32'(n), 32'd12);
        tick();
        chk("held_idle_gap", 32'({m_busy, m_done}), 32'd0);
        tick();
        chk("held_restart", 32'(m_busy), 32'd1);
        go = 1'b0;
        wait_done(100, n2);
        chk("held_second_latency", 32'(n2), 32'd12);
        tick();
        tick();
        chk("held_stops", 32'(m_busy), 32'd0);

        // reset while vector 10 is in DRIVE
        mode0 = 3'd1;
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (6) tick();
        chk("pre_rst_ab", 32'(m_ab), 32'd2);
        chk("pre_rst_err", m_err, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ab", 32'(m_ab), 32'd0);
        chk("mid_rst_busy", 32'(m_busy), 32'd0);
        chk("mid_rst_err", m_err, 32'd0);
        chk("mid_rst_done", 32'(m_done), 32'd0);
        wait_done(30, n);
        chk("no_done_after_rst", 32'(n), 32'd30);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gate_bist_checker.md
# gate_bist_checker

Synthesizable built-in self-test sequencer and response checker for the `basic_gates` block. On a start pulse it drives all four `{a,b}` input combinations into a `basic_gates` instance. After a programmable settle time it samples the seven gate outputs and compares them against a golden model. It then reports pass/fail and a saturating mismatch count. It sits beside `basic_gates` in hardware and plays the role a bench plays in simulation: it generates stimulus and checks the response.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range ≥1.
- `PASSES`, default 1: number of full 4-vector sweeps per run; legal range ≥1.
- `ERR_W`, default 4: width of the mismatch counter.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  run request, sampled only in IDLE.
- `a`  out  1  stimulus to the gate block; registered.
- `b`  out  1  stimulus to the gate block; registered.
- `gate_out`  in  7  response, packed as {and,or,not,nand,nor,xor,xnor}, i.e. [6]=and … [0]=xnor.
- `busy`  out  1  high from the first DRIVE cycle through the DONE cycle.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  1 when `err_cnt`==0 at end of run; valid from `done`, held until next start.
- `err_cnt`  out  ERR_W  mismatching vectors this run, saturating at 2^ERR_W−1.
- `first_err_vec`  out  2  `{a,b}` of the first mismatch (see Configuration).
- `first_err_mask`  out  7  XOR of `gate_out` and golden at the first mismatch (see Configuration).

## Operation
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `first_err_vec`=0, `first_err_mask`=0; state IDLE.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
  - IDLE & `start` → DRIVE. Vector index is 0, pass index is 0, `err_cnt` is cleared, `pass` is cleared, and `{a,b}` is set to 2'b00.
  - DRIVE: hold for SETTLE_CYCLES cycles (down-counter), then go to SAMPLE.
  - SAMPLE (one cycle): compare `gate_out` to golden(`a`,`b`). On any bit difference, increment `err_cnt` (saturating). Then:
    - if vector 3 of the last pass → DONE;
    - otherwise advance the vector (3 wraps to 0 and increments the pass index), drive the new `{a,b}`, and go to DRIVE.
  - DONE: `done`=1 and `pass` is loaded from `err_cnt`==0; next state IDLE. `a`,`b` return to 0.
- Golden model: and=a&b, or=a|b, not=~a, nand=~(a&b), nor=~(a|b), xor=a^b, xnor=~(a^b).
  - Example: `{a,b}`=10 → golden 7'b0101010.
- Mismatch is counted once per vector sample, not once per bit.
- `start` is ignored outside IDLE. If `start` is held high, a new run begins on the cycle after IDLE is re-entered.
- Reset mid-run: the next cycle shows all reset values and no `done` is produced.

## Timing
- If `start` is sampled in IDLE at edge k, then:
  - `busy` and `{a,b}`=00 are visible from cycle k+1;
  - each vector occupies SETTLE_CYCLES+1 cycles;
  - `done` is high in cycle k+1+PASSES·4·(SETTLE_CYCLES+1).
- `gate_out` is compared combinationally in the SAMPLE cycle. `err_cnt` and the first-error registers update at the end of that cycle.
- Minimum gap between consecutive `done` pulses is 4·PASSES·(S+1)+2 cycles: one IDLE cycle plus one acceptance cycle.

## Configuration
- `GATE_BIST_ERRLOG_EN` defined:
  - On the first mismatch of a run, `first_err_vec` captures `{a,b}` and `first_err_mask` captures `gate_out`^golden.
  - Both hold until the next accepted start, which clears them to 0.
- `GATE_BIST_ERRLOG_EN` not defined: `first_err_vec` and `first_err_mask` are tied to 0 and no capture registers are built. All other behaviour is identical.

## Structure
- Package `gate_bist_pkg`:
  - FSM state enum;
  - bit-index constants for the `gate_out` packing (AND_IDX=6 … XNOR_IDX=0);
  - the vector count constant NUM_VEC=4.
- Sub-module `gate_golden_model`: combinational, with inputs `a`,`b` and a 7-bit expected output. It is reusable by other gate-level checkers.

## Test plan
- Correct `basic_gates` attached, S=2, P=1, `start` at cycle 10 → `{a,b}` steps 00,01,10,11 for 3 cycles each; `done` at cycle 23; `pass`=1; `err_cnt`=0.
- `gate_out[0]` (xnor, packed index 0) forced to 0 → the golden xnor value is 1 for vectors 00 and 11, so those mismatch. Expect `err_cnt`=2, `pass`=0; with the macro, `first_err_vec`=00 and `first_err_mask`=7'b0000001.
- ERR_W=2, P=2, `gate_out` forced to ~golden → 8 mismatching samples; `err_cnt` saturates at 3; `pass`=0.
- Extra `start` pulses during a run → ignored. `start` held high → back-to-back runs, with exactly one IDLE cycle (`busy`=0) between `done` and the next `busy`.
- `rst` asserted while vector 10 is in DRIVE → next cycle `a`=`b`=0, `busy`=0, `err_cnt`=0; no `done` pulse follows.
- Macro undefined with the xnor fault injected → `err_cnt`=2; `first_err_vec` and `first_err_mask` remain 0.
